alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 172 +++++++++++++++++
 tb/tb_alu_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes on its input and output.
// Logic, shift and add/sub operations complete in one cycle. When the macro
// ALU_PIPE_MUL_EN is defined, opcode 1111 runs an iterative shift-add multiply
// over WIDTH cycles. Without it, 1111 returns 0 with of=1 (unsupported op).
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             of,
  output logic             zero
);

  localparam logic [3:0] OP_NAND = 4'b0000;
  localparam logic [3:0] OP_NOR  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_LSR  = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_ADDC = 4'b1001;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             alu_of;
  logic [WIDTH-1:0] bx;
  logic             ci;
  logic [WIDTH:0]   sum;

  logic             idle;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] ld_res;
  logic             ld_cout;
  logic             ld_of;

  // Single-cycle datapath: result and flags for every non-iterative opcode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a latch behind.
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_of   = 1'b0;
    // SUB reuses the adder as a + ~b + 1, so cout=1 means "no borrow".
    bx  = (opcode == OP_SUB) ? ~b : b;
    ci  = (opcode == OP_SUB) ? 1'b1 : ((opcode == OP_ADDC) ? cin : 1'b0);
    sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, ci};
    case (opcode)
      OP_NAND: alu_res = ~(a & b);
      OP_NOR:  alu_res = ~(a | b);
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_LSR: begin
        alu_res  = a >> 1;
        alu_cout = a[0];
      end
      OP_ADD, OP_ADDC, OP_SUB: begin
        alu_res  = sum[WIDTH-1:0];
        alu_cout = sum[WIDTH];
        alu_of   = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
`ifndef ALU_PIPE_MUL_EN
      OP_MUL:  alu_of = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic               is_mul;
  logic               mul_done;

  assign idle     = (state == S_IDLE);
  assign is_mul   = (opcode == OP_MUL);
  // Once b_sh has shifted empty, acc_next == acc, so a stalled completion
  // keeps presenting the same product.
  assign acc_next = b_sh[0] ? (acc + a_sh) : acc;
  assign mul_done = (state == S_MUL) && (cnt == '0) && (!out_valid || out_ready);

  // Select what the output registers load: a finished product or the ALU.
  always_comb begin
    load    = (accept && !is_mul) || mul_done;
    ld_res  = alu_res;
    ld_cout = alu_cout;
    ld_of   = alu_of;
    if (mul_done) begin
      ld_res  = acc_next[WIDTH-1:0];
      ld_cout = 1'b0;
      ld_of   = |acc_next[2*WIDTH-1:WIDTH];
    end
  end

  // Multiply sequencer: one shift-add step per cycle, WIDTH steps per product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
    end else if (accept && is_mul) begin
      state <= S_MUL;
      cnt   <= CW'(WIDTH - 1);
      acc   <= '0;
      a_sh  <= {{WIDTH{1'b0}}, a};
      b_sh  <= b;
    end else if (state == S_MUL) begin
      acc  <= acc_next;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      if (cnt != '0) cnt <= cnt - 1'b1;
      else if (mul_done) state <= S_IDLE;
    end
  end
`else
  assign idle = 1'b1;

  // Without the multiplier every accepted request loads the outputs directly.
  always_comb begin
    load    = accept;
    ld_res  = alu_res;
    ld_cout = alu_cout;
    ld_of   = alu_of;
  end
`endif

  assign in_ready = rst_n && idle && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Output registers: load a new result, or drop valid once it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      of        <= 1'b0;
      zero      <= 1'b0;
    end else if (load) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      out_valid <= 1'b1;
      result    <= ld_res;
      cout      <= ld_cout;
      of        <= ld_of;
      zero      <= (ld_res == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: a WIDTH=4 and a WIDTH=8 instance, a
// reference model feeding per-instance expected-result queues, and directed
// latency, backpressure and mid-multiply reset scenarios.
module tb_alu_pipe;

  localparam logic [3:0] OP_NAND = 4'b0000;
  localparam logic [3:0] OP_NOR  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_LSR  = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_ADDC = 4'b1001;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       o;
    logic       z;
    logic       chk_z;
  } exp_t;

  logic clk;
  logic rst_n;

  logic       in_valid  [2];
  logic       cin       [2];
  logic       out_ready [2];
  logic [3:0] opcode    [2];
  logic [7:0] a         [2];
  logic [7:0] b         [2];

  logic       in_ready  [2];
  logic       out_valid [2];
  logic       cout_o    [2];
  logic       of_o      [2];
  logic       zero_o    [2];
  logic [7:0] res       [2];

  logic       rdy4, vld4, co4, ov4, z4;
  logic [3:0] res4;
  logic       rdy8, vld8, co8, ov8, z8;
  logic [7:0] res8;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q0[$];
  exp_t q1[$];

  alu_pipe #(.WIDTH(4)) u_alu4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(rdy4),
    .a(a[0][3:0]), .b(b[0][3:0]), .opcode(opcode[0]), .cin(cin[0]),
    .out_valid(vld4), .out_ready(out_ready[0]), .result(res4),
    .cout(co4), .of(ov4), .zero(z4)
  );

  alu_pipe #(.WIDTH(8)) u_alu8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(rdy8),
    .a(a[1]), .b(b[1]), .opcode(opcode[1]), .cin(cin[1]),
    .out_valid(vld8), .out_ready(out_ready[1]), .result(res8),
    .cout(co8), .of(ov8), .zero(z8)
  );

  always_comb begin
    in_ready[0] = rdy4;  out_valid[0] = vld4;  cout_o[0] = co4;
    of_o[0]     = ov4;   zero_o[0]    = z4;    res[0]    = {4'h0, res4};
    in_ready[1] = rdy8;  out_valid[1] = vld8;  cout_o[1] = co8;
    of_o[1]     = ov8;   zero_o[1]    = z8;    res[1]    = res8;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, written arithmetically on ints for a w-bit ALU.
  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input logic [7:0] av, input logic [7:0] bv, input logic ci);
    exp_t e;
    int   mask, bx, cii, s, p;
    mask    = (1 << w) - 1;
    e       = '0;
    e.chk_z = 1'b1;
    case (op)
      OP_NAND: e.r = 8'((~(int'(av) & int'(bv))) & mask);
      OP_NOR:  e.r = 8'((~(int'(av) | int'(bv))) & mask);
      OP_XOR:  e.r = 8'((int'(av) ^ int'(bv)) & mask);
      OP_NOT:  e.r = 8'((~int'(av)) & mask);
      OP_LSR: begin
        e.r = 8'(int'(av) >> 1);
        e.c = av[0];
      end
      OP_ADD, OP_ADDC, OP_SUB: begin
        bx  = (op == OP_SUB) ? ((~int'(bv)) & mask) : int'(bv);
        cii = (op == OP_ADD) ? 0 : ((op == OP_ADDC) ? int'(ci) : 1);
        s   = int'(av) + bx + cii;
        e.r = 8'(s & mask);
        e.c = ((s >> w) & 1) == 1;
        e.o = ((((int'(av) >> (w-1)) & 1) == ((bx >> (w-1)) & 1)) &&
               (((s >> (w-1)) & 1) != ((int'(av) >> (w-1)) & 1)));
      end
      OP_MUL: begin
`ifdef ALU_PIPE_MUL_EN
        p   = int'(av) * int'(bv);
        e.r = 8'(p & mask);
        e.o = (p >> w) != 0;
`else
        e.o = 1'b1;
`endif
      end
      default: e.chk_z = 1'b0;
    endcase
    e.z = (e.r == 8'h00);
    return e;
  endfunction

  // Present one request to instance d; returns once it is accepted, with the
  // number of extra cycles it waited for in_ready.
  task automatic issue(input int d, input logic [3:0] op, input logic [7:0] av,
                       input logic [7:0] bv, input logic ci, output int waited);
    logic [7:0] am, bm;
    exp_t e;
    am = (d == 0) ? (av & 8'h0f) : av;
    bm = (d == 0) ? (bv & 8'h0f) : bv;
    in_valid[d] = 1'b1;
    opcode[d]   = op;
    a[d]        = am;
    b[d]        = bm;
    cin[d]      = ci;
    waited      = 0;
    @(negedge clk);
    while (!in_ready[d] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready[d]) begin
      check("issue_timeout", 32'd0, 32'd1);
      in_valid[d] = 1'b0;
    end else begin
      e = model((d == 0) ? 4 : 8, op, am, bm, ci);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
    end
  endtask

  // Scoreboard: compare each result on the cycle it is consumed.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst_n && out_valid[d] && out_ready[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          check($sformatf("d%0d_unexpected_result", d), 32'd1, 32'd0);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("d%0d_result", d), res[d], e.r);
          check($sformatf("d%0d_cout", d), cout_o[d], e.c);
          check($sformatf("d%0d_of", d), of_o[d], e.o);
          if (e.chk_z) check($sformatf("d%0d_zero", d), zero_o[d], e.z);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int w;
    logic [3:0] ops [11];
    ops = '{OP_NAND, OP_NOR, OP_XOR, OP_NOT, OP_LSR, OP_ADD, OP_ADDC,
            OP_SUB, OP_MUL, 4'b0011, 4'b0111};
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; cin[d] = 1'b0; out_ready[d] = 1'b1;
      opcode[d] = '0; a[d] = '0; b[d] = '0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_valid", d), out_valid[d], 1'b0);
      check($sformatf("d%0d_rst_ready", d), in_ready[d], 1'b0);
      check($sformatf("d%0d_rst_result", d), res[d], 8'h00);
      check($sformatf("d%0d_rst_flags", d), {cout_o[d], of_o[d], zero_o[d]}, 3'b000);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed WIDTH=4 vectors, plus single-cycle latency on the first ADD.
    issue(0, OP_ADD, 8'h6, 8'h3, 1'b0, w);
    @(negedge clk);
    check("add_latency_valid", out_valid[0], 1'b1);
    @(posedge clk); #1;
    issue(0, OP_ADDC, 8'h7, 8'h5, 1'b1, w);
    issue(0, OP_SUB,  8'h7, 8'h5, 1'b0, w);
    issue(0, OP_NAND, 8'h6, 8'hf, 1'b0, w);
    issue(0, OP_NOR,  8'h6, 8'h1, 1'b0, w);
    issue(0, OP_XOR,  8'h5, 8'hf, 1'b0, w);
    issue(0, OP_NOT,  8'hd, 8'h0, 1'b0, w);
    issue(0, OP_LSR,  8'h5, 8'h0, 1'b0, w);
    issue(0, 4'b0011, 8'hf, 8'hf, 1'b1, w);
    check("b2b_issue_wait", w, 0);
    issue(0, OP_SUB,  8'h3, 8'h3, 1'b0, w);

    // WIDTH=8 multiply: latency and busy in_ready.
    issue(1, OP_MUL, 8'h0c, 8'h0b, 1'b0, w);
`ifdef ALU_PIPE_MUL_EN
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("mul_lat_valid_k%0d", k), out_valid[1], (k == 8));
      if (k < 8) check($sformatf("mul_busy_ready_k%0d", k), in_ready[1], 1'b0);
    end
`else
    @(negedge clk);
    check("mul_lat_valid", out_valid[1], 1'b1);
`endif
    @(posedge clk); #1;
    issue(1, OP_MUL, 8'h20, 8'h10, 1'b0, w);
    issue(1, OP_ADD, 8'h7f, 8'h01, 1'b0, w);

    // Backpressure: the pending result must hold still for five cycles.
    repeat (12) @(posedge clk);
    #1 out_ready[0] = 1'b0;
    issue(0, OP_ADD, 8'h3, 8'h4, 1'b0, w);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", in_ready[0], 1'b0);
      check("bp_valid", out_valid[0], 1'b1);
      check("bp_result", res[0], 8'h07);
      check("bp_flags", {cout_o[0], of_o[0], zero_o[0]}, 3'b000);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    issue(0, OP_XOR, 8'h5, 8'hf, 1'b0, w);
    check("bp_release_wait", w, 0);

    // Reset three cycles into a multiply aborts it.
    repeat (3) @(posedge clk);
    #1;
    issue(1, OP_MUL, 8'h0c, 8'h0b, 1'b0, w);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", out_valid[1], 1'b0);
    check("mrst_ready", in_ready[1], 1'b0);
    check("mrst_result", res[1], 8'h00);
    check("mrst_flags", {cout_o[1], of_o[1], zero_o[1]}, 3'b000);
    q0.delete();
    q1.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    issue(1, OP_ADD, 8'h11, 8'h22, 1'b0, w);
    @(negedge clk);
    check("post_rst_add_valid", out_valid[1], 1'b1);
    @(posedge clk); #1;

    // Random traffic on both widths.
    for (int i = 0; i < 40; i++) begin
      issue(i % 2, ops[$urandom_range(0, 10)], 8'($urandom), 8'($urandom), 1'($urandom), w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (20) @(posedge clk);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
